// File: rtl/sm_pkg.sv
// sm_pkg: shared types and constants for the sequencer
//   command byte values, operating mode, pipeline stage, parser state, decoded command strobes
package sm_pkg;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_CLR  = 8'h43;
    localparam logic [7:0] CMD_GO   = 8'h47;
    localparam logic [7:0] CMD_BP   = 8'h42;
    localparam logic [7:0] CMD_DIS  = 8'h44;

    typedef enum logic [1:0] {MODE_HALT, MODE_RUN, MODE_STEP} mode_t;
    typedef enum logic [2:0] {ST_IDLE, ST_IFE0, ST_IFE1, ST_EXEC, ST_WTBK} stage_t;
    typedef enum logic [1:0] {P_CMD, P_ARG_G, P_ARG_B} pstate_t;

    typedef struct packed {
        logic run;
        logic step;
        logic halt;
        logic clr;
        logic go;
        logic bp;
        logic dis;
    } cmd_t;
endpackage

// File: rtl/sm_if.sv
// sm_if: sequencer bus bundle
//   master (sequencer): takes rx_valid/rx_data/pc/snd_ack, drives stage strobes, run, pulses and status
//   slave  (datapath/UART side): the mirror image
interface sm_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] pc;
    logic       s00_idle;
    logic       s01_ife0;
    logic       s02_ife1;
    logic       s03_exec;
    logic       s04_wtbk;
    logic       run;
    logic       start_trush;
    logic       cpu_start;
    logic [7:0] start_addr;
    logic       snd_req;
    logic       snd_ack;
    logic       halted;
    logic       bp_hit;

    modport master (
        input  rx_valid, rx_data, pc, snd_ack,
        output s00_idle, s01_ife0, s02_ife1, s03_exec, s04_wtbk, run,
               start_trush, cpu_start, start_addr, snd_req, halted, bp_hit
    );

    modport slave (
        output rx_valid, rx_data, pc, snd_ack,
        input  s00_idle, s01_ife0, s02_ife1, s03_exec, s04_wtbk, run,
               start_trush, cpu_start, start_addr, snd_req, halted, bp_hit
    );
endinterface

// File: rtl/sm_cmd_parser.sv
// sm_cmd_parser: UART command byte parser with argument timeout
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx_valid_i  : received byte strobe
//   rx_data_i   : received byte
//   cmd_o       : one-cycle decoded command strobes (go/bp fire on the argument byte)
//   arg_o       : argument byte, valid with cmd_o.go / cmd_o.bp
module sm_cmd_parser
    import sm_pkg::*;
#(
    parameter logic [15:0] ARG_TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output cmd_t       cmd_o,
    output logic [7:0] arg_o
);
    pstate_t     st_q, st_d;
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= P_CMD;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts idle cycles spent in an ARG state; it restarts from 0 on every entry
    always_comb begin
        st_d  = st_q;
        cnt_d = '0;
        cmd_o = '0;
        arg_o = rx_data_i;
        if (st_q == P_CMD) begin
            if (rx_valid_i) begin
                cmd_o.run  = rx_data_i == CMD_RUN;
                cmd_o.step = rx_data_i == CMD_STEP;
                cmd_o.halt = rx_data_i == CMD_HALT;
                cmd_o.clr  = rx_data_i == CMD_CLR;
                cmd_o.dis  = rx_data_i == CMD_DIS;
                st_d = rx_data_i == CMD_GO ? P_ARG_G : rx_data_i == CMD_BP ? P_ARG_B : P_CMD;
            end
        end else if (rx_valid_i) begin
            cmd_o.go = st_q == P_ARG_G;
            cmd_o.bp = st_q == P_ARG_B;
            st_d     = P_CMD;
        end else if (cnt_q == ARG_TIMEOUT - 16'd1) begin
            st_d = P_CMD;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end
endmodule

// File: rtl/sm_sequencer.sv
// sm_sequencer: five-stage instruction sequencer with UART command control, breakpoint and step trace
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sm_if.master -- rx byte, pc and snd_ack in; stage strobes, run, start pulses,
//                snd_req, halted and bp_hit out
module sm_sequencer
    import sm_pkg::*;
#(
    parameter logic [15:0] ARG_TIMEOUT = 16'd50000,
    parameter bit          TRACE_EN    = 1'b1
) (
    input logic  clk,
    input logic  rst_n,
    sm_if.master bus
);
    stage_t     stage_q, stage_d;
    mode_t      mode_q, mode_d;
    logic       bp_en_q, bp_en_d;
    logic [7:0] bp_addr_q, bp_addr_d;
    logic       step_pending_q, step_pending_d;
    logic       bp_skip_q, bp_skip_d;
    logic       bp_hit_q, bp_hit_d;
    logic       stepped_q, stepped_d;
    logic       snd_req_q, snd_req_d;
    logic       start_trush_q, start_trush_d;
    logic       cpu_start_q, cpu_start_d;
    logic [7:0] start_addr_q, start_addr_d;
    cmd_t       cmd;
    logic [7:0] arg;
    logic       idle, halted, bp_stop, run;

    sm_cmd_parser #(.ARG_TIMEOUT(ARG_TIMEOUT)) u_parser (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid_i (bus.rx_valid),
        .rx_data_i  (bus.rx_data),
        .cmd_o      (cmd),
        .arg_o      (arg)
    );

    assign idle    = stage_q == ST_IDLE;
    assign halted  = mode_q == MODE_HALT && idle;
    assign bp_stop = bp_en_q && bus.pc == bp_addr_q && idle && mode_q == MODE_RUN && !bp_skip_q;
    assign run     = idle && ((mode_q == MODE_RUN && !bp_stop) || step_pending_q) && !snd_req_q;

    assign bus.s00_idle    = idle;
    assign bus.s01_ife0    = stage_q == ST_IFE0;
    assign bus.s02_ife1    = stage_q == ST_IFE1;
    assign bus.s03_exec    = stage_q == ST_EXEC;
    assign bus.s04_wtbk    = stage_q == ST_WTBK;
    assign bus.run         = run;
    assign bus.start_trush = start_trush_q;
    assign bus.cpu_start   = cpu_start_q;
    assign bus.start_addr  = start_addr_q;
    assign bus.snd_req     = snd_req_q;
    assign bus.halted      = halted;
    assign bus.bp_hit      = bp_hit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q        <= ST_IDLE;
            mode_q         <= MODE_HALT;
            bp_en_q        <= 1'b0;
            bp_addr_q      <= '0;
            step_pending_q <= 1'b0;
            bp_skip_q      <= 1'b0;
            bp_hit_q       <= 1'b0;
            stepped_q      <= 1'b0;
            snd_req_q      <= 1'b0;
            start_trush_q  <= 1'b0;
            cpu_start_q    <= 1'b0;
            start_addr_q   <= '0;
        end else begin
            stage_q        <= stage_d;
            mode_q         <= mode_d;
            bp_en_q        <= bp_en_d;
            bp_addr_q      <= bp_addr_d;
            step_pending_q <= step_pending_d;
            bp_skip_q      <= bp_skip_d;
            bp_hit_q       <= bp_hit_d;
            stepped_q      <= stepped_d;
            snd_req_q      <= snd_req_d;
            start_trush_q  <= start_trush_d;
            cpu_start_q    <= cpu_start_d;
            start_addr_q   <= start_addr_d;
        end
    end

    always_comb begin
        stage_d = stage_q;
        case (stage_q)
            ST_IDLE: stage_d = run ? ST_IFE0 : ST_IDLE;
            ST_IFE0: stage_d = ST_IFE1;
            ST_IFE1: stage_d = ST_EXEC;
            ST_EXEC: stage_d = ST_WTBK;
            default: stage_d = ST_IDLE;
        endcase
        mode_d         = cmd.run ? MODE_RUN : cmd.step ? MODE_STEP : (cmd.halt || bp_stop) ? MODE_HALT : mode_q;
        bp_en_d        = cmd.bp ? 1'b1 : cmd.dis ? 1'b0 : bp_en_q;
        bp_addr_d      = cmd.bp ? arg : bp_addr_q;
        step_pending_d = cmd.step ? 1'b1 : run ? 1'b0 : step_pending_q;
        // resuming from a breakpoint must fetch the breakpoint instruction once before re-arming
        bp_skip_d      = ((cmd.run || cmd.step) && bp_hit_q) ? 1'b1 : stage_q == ST_IFE0 ? 1'b0 : bp_skip_q;
        bp_hit_d       = bp_stop ? 1'b1 : (cmd.clr && halted) ? 1'b0 : bp_hit_q;
        // remembers whether the instruction in flight was launched by a step request
        stepped_d      = run ? step_pending_q : stepped_q;
        snd_req_d      = (TRACE_EN && stage_q == ST_WTBK && stepped_q) ? 1'b1 : bus.snd_ack ? 1'b0 : snd_req_q;
        start_trush_d  = cmd.clr && halted;
        cpu_start_d    = cmd.go && halted;
        start_addr_d   = (cmd.go && halted) ? arg : start_addr_q;
    end
endmodule

// File: tb/tb_sm_sequencer.sv
// tb_sm_sequencer: scenario bench for sm_sequencer with a pc datapath model and pulse scoreboard
module tb_sm_sequencer;
    import sm_pkg::*;

    localparam logic [15:0] TO = 16'd20;
    localparam logic [4:0] SEQ [5] = '{5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};

    typedef struct {
        bit         trush;
        logic [7:0] addr;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];
    logic [7:0] fetch_pc[$];
    bit   ok;

    always #5 clk = ~clk;

    sm_if bus();

    sm_sequencer #(.ARG_TIMEOUT(TO), .TRACE_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wire [4:0] stages = {bus.s00_idle, bus.s01_ife0, bus.s02_ife1, bus.s03_exec, bus.s04_wtbk};

    initial bus.pc = 8'h00;
    always @(posedge clk) begin
        if (bus.start_trush) bus.pc <= 8'h00;
        else if (bus.cpu_start) bus.pc <= bus.start_addr;
        else if (bus.s04_wtbk) bus.pc <= bus.pc + 8'h01;
    end

    always @(negedge clk) begin
        ev_t e;
        n_checks++;
        if ($countones(stages) != 1) begin
            n_fail++;
            $display("FAIL onehot_stage got=%b required exactly one bit", stages);
        end
        if (bus.cpu_start || bus.start_trush) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse cpu_start=%b start_trush=%b start_addr=%h required none",
                         bus.cpu_start, bus.start_trush, bus.start_addr);
            end else begin
                e = exp_q.pop_front();
                if (bus.start_trush !== e.trush || bus.cpu_start !== !e.trush || (!e.trush && bus.start_addr !== e.addr)) begin
                    n_fail++;
                    $display("FAIL pulse_match got trush=%b start=%b addr=%h required trush=%b addr=%h",
                             bus.start_trush, bus.cpu_start, bus.start_addr, e.trush, e.addr);
                end
            end
        end
        if (bus.s01_ife0) fetch_pc.push_back(bus.pc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_for(input int sel, input int max, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if ((sel == 0 && bus.s01_ife0) || (sel == 1 && bus.halted) || (sel == 2 && bus.bp_hit) ||
                (sel == 3 && bus.s03_exec) || (sel == 4 && bus.snd_req) || (sel == 5 && bus.s04_wtbk)) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (stages !== 5'b10000) begin n_fail++; $display("FAIL reset_stages got=%b required=10000", stages); end
        n_checks++;
        if ({bus.run, bus.start_trush, bus.cpu_start, bus.snd_req} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pulses got run/trush/start/snd=%b required=0000",
                     {bus.run, bus.start_trush, bus.cpu_start, bus.snd_req});
        end
        n_checks++;
        if (bus.start_addr !== 8'h00) begin n_fail++; $display("FAIL reset_start_addr got=%h required=00", bus.start_addr); end
        n_checks++;
        if ({bus.halted, bus.bp_hit} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_status got halted/bp_hit=%b required=10", {bus.halted, bus.bp_hit});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_go_run;
        exp_q.push_back('{1'b0, 8'h10});
        send_byte(CMD_GO);
        send_byte(8'h10);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL go_pulse missing pending=%0d required=0", exp_q.size()); end
        n_checks++;
        if (bus.pc !== 8'h10) begin n_fail++; $display("FAIL go_pc got=%h required=10", bus.pc); end
        fetch_pc.delete();
        send_byte(CMD_RUN);
        wait_for(0, 10, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL run_start got no IFE0 required IFE0 within 10"); end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            n_checks++;
            if (stages !== SEQ[(k + 1) % 5] || (bus.s00_idle && !bus.run)) begin
                n_fail++;
                $display("FAIL run_sequence step=%0d got stages=%b run=%b required stages=%b run=1",
                         k, stages, bus.run, SEQ[(k + 1) % 5]);
            end
        end
        send_byte(CMD_HALT);
        wait_for(1, 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL run_halt got halted=0 required halted=1"); end
        for (int i = 0; i < fetch_pc.size(); i++) begin
            n_checks++;
            if (fetch_pc[i] !== 8'h10 + 8'(i)) begin
                n_fail++;
                $display("FAIL run_fetch_pc idx=%0d got=%h required=%h", i, fetch_pc[i], 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_breakpoint;
        exp_q.push_back('{1'b0, 8'h00});
        send_byte(CMD_GO);
        send_byte(8'h00);
        @(negedge clk);
        send_byte(CMD_BP);
        send_byte(8'h05);
        fetch_pc.delete();
        send_byte(CMD_RUN);
        wait_for(2, 100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_wait got bp_hit=0 required bp_hit=1"); end
        n_checks++;
        if ({bus.pc, bus.run, bus.halted} !== {8'h05, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_stop got pc=%h run=%b halted=%b required pc=05 run=0 halted=1", bus.pc, bus.run, bus.halted);
        end
        n_checks++;
        if (fetch_pc.size() != 5 || fetch_pc[fetch_pc.size() - 1] !== 8'h04) begin
            n_fail++;
            $display("FAIL bp_fetches got count=%0d required 5 fetches ending at 04", fetch_pc.size());
        end
        send_byte(CMD_RUN);
        wait_for(0, 10, ok);
        n_checks++;
        if (!ok || bus.pc !== 8'h05) begin
            n_fail++;
            $display("FAIL bp_resume got fetch=%b pc=%h required fetch at 05", ok, bus.pc);
        end
        wait_for(0, 10, ok);
        n_checks++;
        if (!ok || bus.pc !== 8'h06) begin
            n_fail++;
            $display("FAIL bp_continue got fetch=%b pc=%h required fetch at 06", ok, bus.pc);
        end
        send_byte(CMD_HALT);
        wait_for(1, 20, ok);
        send_byte(CMD_DIS);
        n_checks++;
        if (!ok || bus.bp_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_sticky got halted=%b bp_hit=%b required 1 1", ok, bus.bp_hit);
        end
    endtask

    task automatic test_step;
        fetch_pc.delete();
        send_byte(CMD_STEP);
        wait_for(5, 20, ok);
        n_checks++;
        if (!ok || bus.snd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL step_wtbk got reached=%b snd_req=%b required 1 0", ok, bus.snd_req);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.snd_req, bus.s00_idle, bus.run} !== 3'b110) begin
            n_fail++;
            $display("FAIL step_snd_rise got snd/idle/run=%b required=110", {bus.snd_req, bus.s00_idle, bus.run});
        end
        repeat (7) begin
            @(negedge clk);
            n_checks++;
            if (bus.snd_req !== 1'b1 || bus.s01_ife0 !== 1'b0) begin
                n_fail++;
                $display("FAIL step_hold got snd_req=%b ife0=%b required 1 0", bus.snd_req, bus.s01_ife0);
            end
        end
        bus.snd_ack = 1'b1;
        @(negedge clk);
        bus.snd_ack = 1'b0;
        n_checks++;
        if (bus.snd_req !== 1'b0) begin n_fail++; $display("FAIL step_ack got snd_req=%b required=0", bus.snd_req); end
        repeat (10) @(negedge clk);
        n_checks++;
        if (fetch_pc.size() != 1) begin
            n_fail++;
            $display("FAIL step_count got fetches=%0d required=1", fetch_pc.size());
        end
        send_byte(CMD_HALT);
        wait_for(1, 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL step_halt got halted=0 required=1"); end
    endtask

    task automatic test_timeout;
        exp_q.push_back('{1'b0, 8'h20});
        send_byte(CMD_GO);
        repeat (int'(TO) - 2) @(negedge clk);
        send_byte(8'h20);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || bus.pc !== 8'h20) begin
            n_fail++;
            $display("FAIL arg_last_cycle got pending=%0d pc=%h required 0 20", exp_q.size(), bus.pc);
        end
        send_byte(CMD_GO);
        repeat (int'(TO) + 2) @(negedge clk);
        send_byte(CMD_RUN);
        wait_for(0, 10, ok);
        n_checks++;
        if (!ok || bus.pc !== 8'h20) begin
            n_fail++;
            $display("FAIL timeout_run got fetch=%b pc=%h required fetch at 20", ok, bus.pc);
        end
        send_byte(CMD_HALT);
        wait_for(1, 20, ok);
    endtask

    task automatic test_clear;
        send_byte(CMD_RUN);
        wait_for(0, 10, ok);
        send_byte(CMD_CLR);
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.bp_hit !== 1'b1) begin n_fail++; $display("FAIL clr_ignored got bp_hit=%b required=1", bus.bp_hit); end
        send_byte(CMD_HALT);
        wait_for(1, 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL clr_halt got halted=0 required=1"); end
        exp_q.push_back('{1'b1, 8'h00});
        send_byte(CMD_CLR);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || bus.bp_hit !== 1'b0 || bus.pc !== 8'h00) begin
            n_fail++;
            $display("FAIL clr_pulse got pending=%0d bp_hit=%b pc=%h required 0 0 00", exp_q.size(), bus.bp_hit, bus.pc);
        end
    endtask

    task automatic test_reset_mid;
        send_byte(CMD_RUN);
        send_byte(CMD_GO);
        wait_for(3, 10, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rstmid_exec got no EXEC required EXEC"); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({stages, bus.halted, bus.cpu_start, bus.start_trush} !== 8'b10000100) begin
            n_fail++;
            $display("FAIL rstmid_state got stages=%b halted=%b start=%b trush=%b required 10000 1 0 0",
                     stages, bus.halted, bus.cpu_start, bus.start_trush);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fetch_pc.delete();
        send_byte(8'h10);
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.halted !== 1'b1 || fetch_pc.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_after got halted=%b fetches=%0d pending=%0d required 1 0 0",
                     bus.halted, fetch_pc.size(), exp_q.size());
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.snd_ack  = 1'b0;
        test_reset();
        test_go_run();
        test_breakpoint();
        test_step();
        test_timeout();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sm_sequencer.md
SM_SEQUENCER -- requirements
Module: sm_sequencer

Interface
REQ-001 Parameter ARG_TIMEOUT, default 16'd50000, cycles allowed between a command byte and its argument byte.
REQ-002 Parameter TRACE_EN, default 1, enables the status-send handshake after each single-stepped instruction.
REQ-003 clk  input  1  system clock; one clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_data holds a received UART byte.
REQ-006 rx_data  input  8  received command or argument byte.
REQ-007 pc  input  8  current datapath program counter.
REQ-008 s00_idle, s01_ife0, s02_ife1, s03_exec, s04_wtbk  output  1 each  one-hot stage strobes to the datapath.
REQ-009 run  output  1  permit-fetch qualifier, meaningful only while s00_idle=1.
REQ-010 start_trush  output  1  one-cycle pulse that clears PC and stack.
REQ-011 cpu_start  output  1  one-cycle pulse that loads PC from start_addr.
REQ-012 start_addr  output  8  PC load value, valid while cpu_start=1.
REQ-013 snd_req  output  1  status-send request to the UART transmitter.
REQ-014 snd_ack  input  1  transmitter acknowledge; a one-cycle pulse.
REQ-015 halted  output  1  mode is HALT and stage is IDLE.
REQ-016 bp_hit  output  1  sticky flag: execution stopped at the breakpoint.

Function
REQ-017 Stage FSM IDLE->IFE0->IFE1->EXEC->WTBK->IDLE, one cycle per stage; exactly one stage output is high in every cycle.
REQ-018 Mode register: HALT, RUN or STEP; HALT after reset.
REQ-019 run=1 in IDLE iff ((mode=RUN & ~bp_stop) | step_pending) & ~snd_req; IDLE->IFE0 on the cycle after run=1.
REQ-020 Command bytes, accepted on rx_valid while the parser is in CMD: 0x52 'R' mode<=RUN; 0x53 'S' mode<=STEP and step_pending<=1; 0x48 'H' mode<=HALT.
REQ-021 0x43 'C': accepted only when halted=1; pulses start_trush and clears bp_hit; ignored otherwise.
REQ-022 0x47 'G': parser moves to ARG_G; next byte pulses cpu_start with start_addr=byte (only if halted=1, else dropped); parser returns to CMD.
REQ-023 0x42 'B': parser moves to ARG_B; next byte is loaded into bp_addr and sets bp_en=1; 0x44 'D' clears bp_en.
REQ-024 In an ARG state, any byte value is the argument; unknown bytes in CMD are ignored.
REQ-025 Timeout counter starts at 0 on entry to an ARG state; at ARG_TIMEOUT cycles without rx_valid, parser returns to CMD and no action is taken.
REQ-026 bp_stop = bp_en & (pc==bp_addr) & IDLE & mode=RUN & ~bp_skip; when high, mode<=HALT and bp_hit<=1, with no fetch.
REQ-027 bp_skip is set when 'R' or 'S' is accepted while bp_hit=1; it is cleared after the next IFE0, so resume executes the breakpoint instruction.
REQ-028 step_pending is cleared in the cycle run=1; a repeated 'S' before that has no additional effect.
REQ-029 When TRACE_EN=1 and the instruction was stepped: snd_req rises the cycle after WTBK and holds until snd_ack is sampled high; run is suppressed meanwhile.
REQ-030 'H' mid-instruction: the instruction completes through WTBK, then halted=1.
REQ-031 'H' in the same cycle as a bp_stop: mode=HALT and bp_hit=1.
REQ-032 Command latency: a byte accepted at cycle t takes effect in registers at t+1.

Reset
REQ-033 On rst_n low: stage=IDLE, mode=HALT, parser=CMD, counter=0, bp_en=0, bp_addr=0, step_pending=0, bp_skip=0.
REQ-034 Outputs during reset: s00_idle=1, other stages 0, run=0, start_trush=0, cpu_start=0, start_addr=0, snd_req=0, halted=1, bp_hit=0.
REQ-035 Reset mid-instruction or mid-argument abandons the operation without emitting a pulse.

Structure
REQ-036 Package sm_pkg holds the command byte constants, the mode enum and the stage enum.
REQ-037 Sub-module sm_cmd_parser holds the CMD/ARG_G/ARG_B FSM and the timeout counter, and emits decoded one-cycle command strobes.

Verification
REQ-038 Reset, then 'G',0x10 -> cpu_start pulse with start_addr=0x10; 'R' -> s00..s04 cycle repeats every 5 clocks with run=1 in each IDLE.
REQ-039 'B',0x05 then 'R' with pc reaching 0x05 -> run=0, bp_hit=1, halted=1; then 'R' -> one fetch at 0x05, execution continues.
REQ-040 'S' with TRACE_EN=1 -> exactly one instruction runs, snd_req high after WTBK; snd_ack delayed 7 cycles -> no IFE0 before the ack.
REQ-041 'G', then no byte for ARG_TIMEOUT cycles -> parser back in CMD; next 0x52 is treated as 'R', not as an address.
REQ-042 'C' while running -> no start_trush; 'H', wait for halted=1, then 'C' -> one start_trush pulse, bp_hit=0.
REQ-043 rst_n low during EXEC -> s00_idle=1 immediately, halted=1, no cpu_start or start_trush pulse emitted.
